array_feeder: RTL and testbench

Source end of the search-datapath input stream. On `start`, walks a synchronous-read word memory from address 0 and presents one element at a time on `data` with a `read` strobe. The strobe is held until the search controller signals `ready` (it sits in its READ state). The walk stops when the array is exhausted or the controller reports `stop` (success). It sits between the array memory and the search control/datapath, supplying `read` and the element value.

---
 rtl/array_feeder.sv | 127 ++++++++++++
 tb/tb_array_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_feeder.sv
// Streams elements out of a synchronous-read word memory, one per handshake,
// until the requested count is transferred or the consumer reports success.
module array_feeder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic              ready,
    input  logic              stop,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic              exhausted,
    output logic [ADDR_W:0]   xfer_count
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, OFFER, FINISH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic              last;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    // Compare at ADDR_W+1 bits so a full-size array ends at the top address without wrapping.
    assign last        = ({1'b0, addr} == (len_q - 1'b1));

    // NOTE: all state is non-blocking in one clocked block; reset is synchronous, so it lives inside the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            len_q      <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            data       <= '0;
            index      <= '0;
            read       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exhausted  <= 1'b0;
            xfer_count <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        len_q      <= len_clamped;
                        addr       <= '0;
                        xfer_count <= '0;
                        if (len_clamped == '0) begin
                            state     <= FINISH;
                            done      <= 1'b1;
                            exhausted <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            done      <= 1'b0;
                            exhausted <= 1'b0;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        exhausted <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state     <= FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        exhausted <= 1'b0;
                    end else begin
                        data  <= mem_rdata;
                        index <= addr;
                        read  <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (stop) begin
                        state     <= FINISH;
                        read      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        exhausted <= 1'b0;
                    end else if (ready) begin
                        xfer_count <= xfer_count + 1'b1;
                        read       <= 1'b0;
                        if (last) begin
                            state     <= FINISH;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            exhausted <= 1'b1;
                        end else begin
                            addr      <= addr + 1'b1;
                            mem_addr  <= addr + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_feeder.sv
// Randomised and directed bench for array_feeder, checked every cycle against
// an element/step timeline model plus hand-computed expectations.
module tb_array_feeder;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset, start, ready, stop;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rd_en, read, busy, done, exhausted;
    logic [ADDR_W-1:0] mem_addr, index;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   xfer_count;

    logic [DATA_W-1:0] mem [DEPTH];

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    array_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .ready(ready), .stop(stop), .mem_rdata(mem_rdata),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .data(data),
        .index(index), .read(read), .busy(busy), .done(done),
        .exhausted(exhausted), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Model: mode 0 idle, 1 walking, 2 finished; within a walk, step counts
    // cycles since the current element began (0 fetch, 1 load, 2+ offered).
    int          m_mode = 0, m_elem = 0, m_step = 0, m_len = 0, m_cnt = 0, m_index = 0;
    bit          m_exh = 1'b0;
    logic [7:0]  m_data = '0;

    function void model_step();
        if (reset) begin
            m_mode = 0; m_elem = 0; m_step = 0; m_cnt = 0;
            m_exh = 1'b0; m_data = '0; m_index = 0;
        end else if (m_mode == 1) begin
            if (stop) begin
                m_mode = 2; m_exh = 1'b0;
            end else if (m_step >= 2) begin
                if (ready) begin
                    m_cnt++;
                    if (m_elem == m_len - 1) begin
                        m_mode = 2; m_exh = 1'b1;
                    end else begin
                        m_elem++; m_step = 0;
                    end
                end
            end else begin
                if (m_step == 1) begin
                    m_data  = mem[m_elem];
                    m_index = m_elem;
                end
                m_step++;
            end
        end else if (start) begin
            m_len  = (int'(length) > DEPTH) ? DEPTH : int'(length);
            m_cnt  = 0; m_exh = 1'b0; m_elem = 0; m_step = 0;
            if (m_len == 0) begin
                m_mode = 2; m_exh = 1'b1;
            end else begin
                m_mode = 1;
            end
        end
    endfunction

    always @(posedge clk) model_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       32'(busy),       32'(m_mode == 1));
            check("done",       32'(done),       32'(m_mode == 2));
            check("exhausted",  32'(exhausted),  32'(m_exh));
            check("xfer_count", 32'(xfer_count), 32'(m_cnt));
            check("read",       32'(read),       32'(m_mode == 1 && m_step >= 2));
            check("mem_rd_en",  32'(mem_rd_en),  32'(m_mode == 1 && m_step == 0));
            if (m_mode == 1 && m_step == 0) check("mem_addr", 32'(mem_addr), 32'(m_elem));
            if (m_mode == 0) check("mem_addr_idle", 32'(mem_addr), 32'd0);
            if (m_mode != 1 || m_step >= 2) begin
                check("data",  32'(data),  32'(m_data));
                check("index", 32'(index), 32'(m_index));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_small_mem();
        logic [7:0] vals [4] = '{8'd5, 8'd9, 8'd3, 8'd7};
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 4) ? vals[i] : 8'hEE;
    endtask

    initial begin
        int exp_cyc [4] = '{3, 6, 9, 12};
        int exp_dat [4] = '{5, 9, 3, 7};
        int rd_cyc [4];
        int rd_dat [4];
        int nrd, npulse, held, last_idx, saw3;
        int addrs [4];

        reset = 1'b1; start = 1'b0; length = '0; ready = 1'b0; stop = 1'b0;
        load_small_mem();
        cyc();
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(read), 32'd0);
        check("rst_cnt",  32'(xfer_count), 32'd0);
        reset = 1'b0;
        cyc();

        // Straight walk of four elements with ready tied high.
        start = 1'b1; length = 5'd4; ready = 1'b1; nrd = 0;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            start = 1'b0;
            if (read) begin
                if (nrd < 4) begin rd_cyc[nrd] = c; rd_dat[nrd] = int'(data); end
                nrd++;
            end
            if (c == 13) begin
                check("t1_done", 32'(done), 32'd1);
                check("t1_exh",  32'(exhausted), 32'd1);
                check("t1_cnt",  32'(xfer_count), 32'd4);
            end
        end
        check("t1_nread", 32'(nrd), 32'd4);
        for (int i = 0; i < 4 && i < nrd; i++) begin
            check("t1_read_cycle", 32'(rd_cyc[i]), 32'(exp_cyc[i]));
            check("t1_read_data",  32'(rd_dat[i]), 32'(exp_dat[i]));
        end

        // Consumer stalls for four cycles on element 1.
        start = 1'b1; length = 5'd4; ready = 1'b1; held = 0; npulse = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            start = 1'b0;
            if (read && index == 4'd1) held++;
            if (mem_rd_en) npulse++;
            ready = !(c >= 6 && c <= 9);
        end
        check("t2_held",   32'(held), 32'd5);
        check("t2_pulses", 32'(npulse), 32'd4);
        check("t2_cnt",    32'(xfer_count), 32'd4);

        // Success one cycle after element 2 transfers.
        start = 1'b1; length = 5'd4; ready = 1'b1; nrd = 0; saw3 = 0;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            start = 1'b0;
            if (read) nrd++;
            if (read && index == 4'd3) saw3 = 1;
            stop = (c == 10);
        end
        check("t3_nread", 32'(nrd), 32'd3);
        check("t3_no_el3", 32'(saw3), 32'd0);
        check("t3_cnt",  32'(xfer_count), 32'd3);
        check("t3_exh",  32'(exhausted), 32'd0);
        check("t3_done", 32'(done), 32'd1);

        // Stop and ready together on the first offer.
        start = 1'b1; length = 5'd4; ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            start = 1'b0;
            stop = (c == 3);
        end
        check("t4_cnt",  32'(xfer_count), 32'd0);
        check("t4_exh",  32'(exhausted), 32'd0);
        check("t4_done", 32'(done), 32'd1);

        // Zero length from a fresh idle.
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        start = 1'b1; length = 5'd0; npulse = 0;
        cyc();
        start = 1'b0;
        check("t5_done", 32'(done), 32'd1);
        check("t5_exh",  32'(exhausted), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (mem_rd_en) npulse++;
            cyc();
        end
        check("t5_no_reads", 32'(npulse), 32'd0);

        // Oversized length clamps to the full array.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
        start = 1'b1; length = 5'd20; ready = 1'b1; nrd = 0; last_idx = -1;
        for (int c = 1; c <= 55; c++) begin
            cyc();
            start = 1'b0;
            if (read) begin nrd++; last_idx = int'(index); end
        end
        check("t5_nread", 32'(nrd), 32'd16);
        check("t5_last",  32'(last_idx), 32'd15);
        check("t5_cnt",   32'(xfer_count), 32'd16);
        check("t5_exh2",  32'(exhausted), 32'd1);

        // Reset during the load of element 2, then a clean two-element walk.
        load_small_mem();
        start = 1'b1; length = 5'd4; ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            start = 1'b0;
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_idle", 32'({mem_rd_en, read, busy, done, exhausted}), 32'd0);
        check("t6_outs", 32'({data, index, xfer_count, mem_addr}), 32'd0);
        start = 1'b1; length = 5'd2; npulse = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
            if (mem_rd_en) begin
                if (npulse < 4) addrs[npulse] = int'(mem_addr);
                npulse++;
            end
        end
        check("t6_pulses", 32'(npulse), 32'd2);
        if (npulse >= 2) begin
            check("t6_addr0", 32'(addrs[0]), 32'd0);
            check("t6_addr1", 32'(addrs[1]), 32'd1);
        end

        // Random traffic; memory is only rewritten together with a reset.
        for (int blk = 0; blk < 6; blk++) begin
            reset = 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
            cyc();
            for (int c = 0; c < 500; c++) begin
                reset  = ($urandom_range(0, 199) == 0);
                start  = ($urandom_range(0, 7) == 0);
                length = 5'($urandom_range(0, 31));
                ready  = ($urandom_range(0, 3) != 0);
                stop   = ($urandom_range(0, 39) == 0);
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
